// File: rtl/sliding_window_fifo_pkg.sv
// Shared defaults and width helper for the sliding-window FIFO and its neighbours
// (PE array, fetch controller).
package sliding_window_fifo_pkg;

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_PAR_WRITE = 2;
    localparam int DEF_PAR_READ  = 3;
    localparam int DEF_STRIDE    = 1;

    // Width needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sliding_window_fifo_ring_ptr_add.sv
// Combinational ring address step: (ptr + inc) mod DEPTH.
// The wrap is done with compare-and-subtract, so DEPTH does not need to be a power of two.
module sliding_window_fifo_ring_ptr_add
    import sliding_window_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = clog2_min1(DEPTH)
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [PTR_W:0]   inc,
    output logic [PTR_W-1:0] sum
);

    logic [PTR_W:0] raw;

    // ptr < DEPTH and inc <= DEPTH, so a single subtraction always suffices.
    assign raw = {1'b0, ptr} + inc;
    assign sum = PTR_W'((raw >= (PTR_W+1)'(DEPTH)) ? raw - (PTR_W+1)'(DEPTH) : raw);

endmodule

// File: rtl/sliding_window_fifo.sv
// Ring buffer with PAR_WRITE-wide pushes and a PAR_READ-wide read window
// that retires STRIDE words per pop; feeds overlapping windows to the PE array.
module sliding_window_fifo
    import sliding_window_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int PAR_WRITE = DEF_PAR_WRITE,
    parameter int PAR_READ  = DEF_PAR_READ,
    parameter int STRIDE    = DEF_STRIDE,
    parameter int PTR_W     = clog2_min1(DEPTH),
    parameter int CNT_W     = clog2_min1(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [PAR_WRITE*DATA_W-1:0]   din,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [PAR_READ*DATA_W-1:0]    dout,
    output logic [CNT_W-1:0]              count,
    output logic                          empty
);

    if (STRIDE < 1 || STRIDE > PAR_READ) begin : g_bad_stride
        $error("sliding_window_fifo: STRIDE must be within 1..PAR_READ");
    end
    if (DEPTH < PAR_WRITE || DEPTH < PAR_READ) begin : g_bad_depth
        $error("sliding_window_fifo: DEPTH must be >= max(PAR_WRITE, PAR_READ)");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [PTR_W-1:0]  wr_addr [PAR_WRITE];
    logic [PTR_W-1:0]  rd_addr [PAR_READ];
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic              push, pop;

    // Handshakes look only at the registered count, so a pop never frees space in the same cycle.
    assign wr_ready = (count_q <= CNT_W'(DEPTH - PAR_WRITE));
    assign rd_valid = (count_q >= CNT_W'(PAR_READ));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_ready & rd_valid;

    sliding_window_fifo_ring_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_step (
        .ptr (wr_ptr),
        .inc ((PTR_W+1)'(PAR_WRITE)),
        .sum (wr_ptr_nxt)
    );

    sliding_window_fifo_ring_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_step (
        .ptr (rd_ptr),
        .inc ((PTR_W+1)'(STRIDE)),
        .sum (rd_ptr_nxt)
    );

    for (genvar k = 0; k < PAR_WRITE; k++) begin : g_wr_lane
        sliding_window_fifo_ring_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_addr (
            .ptr (wr_ptr),
            .inc ((PTR_W+1)'(k)),
            .sum (wr_addr[k])
        );
    end

    for (genvar k = 0; k < PAR_READ; k++) begin : g_rd_lane
        sliding_window_fifo_ring_ptr_add #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_addr (
            .ptr (rd_ptr),
            .inc ((PTR_W+1)'(k)),
            .sum (rd_addr[k])
        );
        assign dout[k*DATA_W +: DATA_W] = rd_valid ? mem[rd_addr[k]] : '0;
    end

    always_comb begin
        count_nxt = count_q;
        if (push) count_nxt = count_nxt + CNT_W'(PAR_WRITE);
        if (pop)  count_nxt = count_nxt - CNT_W'(STRIDE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            // Storage is intentionally left as-is; only the bookkeeping is cleared.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_nxt;
                for (int k = 0; k < PAR_WRITE; k++) mem[wr_addr[k]] <= din[k*DATA_W +: DATA_W];
            end
            if (pop) rd_ptr <= rd_ptr_nxt;
            count_q <= count_nxt;
        end
    end

endmodule

// File: tb/tb_sliding_window_fifo.sv
// Scoreboard bench for sliding_window_fifo: a word-queue model predicts each cycle's
// outputs, a negedge monitor compares them against the DUT.
module tb_sliding_window_fifo;

    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int PW    = 2;
    localparam int PR    = 3;
    localparam int STR   = 1;
    localparam int CW    = 4;

    logic              clk = 1'b0;
    logic              rst, flush, wr_valid, rd_ready;
    logic [PW*DW-1:0]  din;
    logic              wr_ready, rd_valid, empty;
    logic [PR*DW-1:0]  dout;
    logic [CW-1:0]     count;

    sliding_window_fifo #(
        .DATA_W(DW), .DEPTH(DEPTH), .PAR_WRITE(PW), .PAR_READ(PR), .STRIDE(STR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .din      (din),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .dout     (dout),
        .count    (count),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              cnt;
        logic            emp;
        logic            wrdy;
        logic            rv;
        logic [PR*DW-1:0] win;
    } exp_t;

    exp_t       exp_q[$];
    logic [DW-1:0] words[$];   // model: oldest word at index 0
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic exp_t predict();
        exp_t e;
        e.cnt  = words.size();
        e.emp  = (words.size() == 0);
        e.wrdy = ((DEPTH - words.size()) >= PW);
        e.rv   = (words.size() >= PR);
        e.win  = '0;
        if (e.rv)
            for (int k = 0; k < PR; k++) e.win[k*DW +: DW] = words[k];
        return e;
    endfunction

    // Applies the current inputs to the model as the clock edge would.
    task automatic model_step();
        bit can_push, can_pop;
        if (rst || flush) begin
            words.delete();
        end else begin
            can_push = wr_valid && ((DEPTH - words.size()) >= PW);
            can_pop  = rd_ready && (words.size() >= PR);
            if (can_pop)
                for (int i = 0; i < STR; i++) void'(words.pop_front());
            if (can_push)
                for (int k = 0; k < PW; k++) words.push_back(din[k*DW +: DW]);
        end
    endtask

    task automatic cycle();
        exp_q.push_back(predict());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step(input bit rs, input bit fl, input bit wv,
                        input logic [PW*DW-1:0] d, input bit rr);
        rst = rs; flush = fl; wr_valid = wv; din = d; rd_ready = rr;
        cycle();
    endtask

    function automatic logic [PW*DW-1:0] pair(input int a, input int b);
        logic [PW*DW-1:0] p;
        p = '0;
        p[0 +: DW]  = DW'(a);
        p[DW +: DW] = DW'(b);
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("count",    32'(count),    32'(e.cnt));
            check("empty",    32'(empty),    32'(e.emp));
            check("wr_ready", 32'(wr_ready), 32'(e.wrdy));
            check("rd_valid", 32'(rd_valid), 32'(e.rv));
            check("dout",     32'(dout),     32'(e.win));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; din = '0;
        @(posedge clk);
        model_step();
        #1;
        step(1, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);

        // fill: (1,2) (3,4) give a first window, then up to full
        step(0, 0, 1, pair(1, 2), 0);
        step(0, 0, 1, pair(3, 4), 0);
        step(0, 0, 1, pair(5, 6), 0);
        step(0, 0, 1, pair(7, 8), 0);
        step(0, 0, 1, pair(9, 9), 0);   // full: ignored
        step(0, 0, 1, pair(9, 9), 0);

        // wrap-around: drain three, push into addresses 0/1, drain three more
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 1, pair(9, 10), 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);

        // count 4 -> 6, simultaneous push+pop -> 7, then pop alone
        step(0, 0, 1, pair(11, 12), 0);
        step(0, 0, 1, pair(10, 11), 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);

        // count 2 with rd_ready held: nothing retires
        step(0, 1, 0, '0, 0);
        step(0, 0, 1, pair(13, 14), 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);

        // count 5 then flush with both handshakes requested
        step(0, 0, 1, pair(15, 1), 0);
        step(0, 0, 1, pair(2, 3), 0);
        step(0, 0, 0, '0, 1);
        step(0, 1, 1, pair(4, 5), 1);
        step(0, 0, 0, '0, 0);
        step(0, 0, 1, pair(6, 7), 0);
        step(0, 0, 1, pair(8, 9), 0);
        step(1, 1, 1, pair(1, 1), 1);
        step(0, 0, 0, '0, 0);

        for (int i = 0; i < 800; i++) begin
            step(($urandom % 200) == 0, ($urandom % 60) == 0, ($urandom % 3) != 0,
                 PW*DW'($urandom), ($urandom % 2) == 1);
        end

        step(0, 0, 0, '0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
